// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register: hold / shift up / shift down / parallel load,
// with optional rotate and an autonomous counted burst-shift engine (BUSY/DONE handshake).
module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             i_clk,
    input  logic             i_mr,
    input  logic [1:0]       i_s,
    input  logic             i_rot,
    input  logic             i_dsr,
    input  logic             i_dsl,
    input  logic [WIDTH-1:0] i_in,
    input  logic             i_start,
    input  logic [CW-1:0]    i_cnt,
    output logic [WIDTH-1:0] o_out,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_out;
    logic [CW-1:0]    r_remain;
    logic             r_dirUp;
    logic             r_rotLatched;
    logic             r_busy;
    logic             r_done;

    logic             w_useRot;
    logic             w_burstReq;
    logic [WIDTH-1:0] w_upNext;
    logic [WIDTH-1:0] w_downNext;

    // During a burst the latched ROT wins; serial inputs are always sampled live.
    assign w_useRot   = (r_state == RUN) ? r_rotLatched : i_rot;
    assign w_upNext   = {r_out[WIDTH-2:0], (w_useRot ? r_out[WIDTH-1] : i_dsr)};
    assign w_downNext = {(w_useRot ? r_out[0] : i_dsl), r_out[WIDTH-1:1]};
    assign w_burstReq = i_start && ((i_s == 2'b01) || (i_s == 2'b10));

    always_ff @(posedge i_clk or posedge i_mr) begin
        if (i_mr) begin
            r_state      <= IDLE;
            r_out        <= '0;
            r_remain     <= '0;
            r_dirUp      <= 1'b0;
            r_rotLatched <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_burstReq) begin
                        // A zero-length burst completes immediately without entering RUN.
                        if (i_cnt != '0) begin
                            r_dirUp      <= (i_s == 2'b01);
                            r_rotLatched <= i_rot;
                            r_remain     <= i_cnt;
                            r_busy       <= 1'b1;
                            r_state      <= RUN;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end else begin
                        case (i_s)
                            2'b01:   r_out <= w_upNext;
                            2'b10:   r_out <= w_downNext;
                            2'b11:   r_out <= i_in;
                            default: r_out <= r_out;
                        endcase
                    end
                end
                RUN: begin
                    r_out    <= r_dirUp ? w_upNext : w_downNext;
                    r_remain <= r_remain - 1'b1;
                    if (r_remain == CW'(1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_out  = r_out;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg: expected {OUT,BUSY,DONE} are queued as each step
// is driven and popped/asserted one cycle later (or immediately for async reset checks).
module tb_universal_shift_reg;

    logic       clk;
    logic       mr;
    logic [1:0] s;
    logic       rot;
    logic       dsr;
    logic       dsl;
    logic [7:0] din;
    logic       start;
    logic [3:0] cnt;
    logic [7:0] dout;
    logic       busy;
    logic       done;

    logic [9:0] expQ[$];
    int         passCount = 0;
    int         totalCount = 0;

    universal_shift_reg #(.WIDTH(8), .CW(4)) dut (
        .i_clk   (clk),
        .i_mr    (mr),
        .i_s     (s),
        .i_rot   (rot),
        .i_dsr   (dsr),
        .i_dsl   (dsl),
        .i_in    (din),
        .i_start (start),
        .i_cnt   (cnt),
        .o_out   (dout),
        .o_busy  (busy),
        .o_done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag);
        logic [9:0] exp;
        totalCount++;
        if (expQ.size() == 0) begin
            $error("FAIL %s: scoreboard empty, got out=%h busy=%b done=%b", tag, dout, busy, done);
        end else begin
            exp = expQ.pop_front();
            assert ({dout, busy, done} === exp) passCount++;
            else $error("FAIL %s: got out=%h busy=%b done=%b, expected out=%h busy=%b done=%b",
                        tag, dout, busy, done, exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [1:0] iS, input logic iRot,
                                 input logic iDsr, input logic iDsl, input logic [7:0] iIn,
                                 input logic iStart, input logic [3:0] iCnt,
                                 input logic [7:0] eOut, input logic eBusy, input logic eDone);
        s = iS; rot = iRot; dsr = iDsr; dsl = iDsl; din = iIn; start = iStart; cnt = iCnt;
        expQ.push_back({eOut, eBusy, eDone});
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic [7:0] rotExp;
        mr = 1'b1; s = 2'b00; rot = 1'b0; dsr = 1'b0; dsl = 1'b0;
        din = 8'h00; start = 1'b0; cnt = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        expQ.push_back({8'h00, 1'b0, 1'b0});
        checkOutput("reset");
        mr = 1'b0;

        applyStimulus("loadA5", 2'b11, 0, 0, 0, 8'hA5, 0, 0, 8'hA5, 0, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus("holdA5", 2'b00, 0, 0, 0, 8'h00, 0, 0, 8'hA5, 0, 0);

        applyStimulus("load80a", 2'b11, 0, 0, 0, 8'h80, 0, 0, 8'h80, 0, 0);
        applyStimulus("upRot", 2'b01, 1, 0, 0, 8'h00, 0, 0, 8'h01, 0, 0);
        applyStimulus("load80b", 2'b11, 0, 0, 0, 8'h80, 0, 0, 8'h80, 0, 0);
        applyStimulus("upDsr0", 2'b01, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        applyStimulus("load01", 2'b11, 0, 0, 0, 8'h01, 0, 0, 8'h01, 0, 0);
        applyStimulus("downDsl1", 2'b10, 0, 0, 1, 8'h00, 0, 0, 8'h80, 0, 0);

        // Rotating burst down by 3; S/IN/ROT/START scrambled while running
        applyStimulus("bLoad01", 2'b11, 0, 0, 0, 8'h01, 0, 0, 8'h01, 0, 0);
        applyStimulus("bAccept", 2'b10, 1, 0, 0, 8'h00, 1, 3, 8'h01, 1, 0);
        applyStimulus("bShift1", 2'($urandom_range(0, 3)), 1'($urandom), 0, 1, 8'($urandom), 1'($urandom), 4'($urandom), 8'h80, 1, 0);
        applyStimulus("bShift2", 2'($urandom_range(0, 3)), 1'($urandom), 0, 1, 8'($urandom), 1'($urandom), 4'($urandom), 8'h40, 1, 0);
        applyStimulus("bShift3", 2'($urandom_range(0, 3)), 1'($urandom), 0, 1, 8'($urandom), 1'($urandom), 4'($urandom), 8'h20, 0, 1);
        applyStimulus("bAfter", 2'b00, 0, 0, 0, 8'h00, 0, 0, 8'h20, 0, 0);

        // Abort a long burst with an asynchronous reset mid-cycle
        applyStimulus("aLoad00", 2'b11, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        applyStimulus("aAccept", 2'b01, 0, 1, 0, 8'h00, 1, 10, 8'h00, 1, 0);
        applyStimulus("aShift1", 2'b01, 0, 1, 0, 8'h00, 0, 0, 8'h01, 1, 0);
        applyStimulus("aShift2", 2'b01, 0, 1, 0, 8'h00, 0, 0, 8'h03, 1, 0);
        #2 mr = 1'b1;
        #1;
        expQ.push_back({8'h00, 1'b0, 1'b0});
        checkOutput("asyncMR");
        @(posedge clk);
        #1;
        expQ.push_back({8'h00, 1'b0, 1'b0});
        checkOutput("heldMR");
        mr = 1'b0;
        applyStimulus("postAbort", 2'b00, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        applyStimulus("rAccept", 2'b01, 0, 1, 0, 8'h00, 1, 2, 8'h00, 1, 0);
        applyStimulus("rShift1", 2'b00, 0, 1, 0, 8'h00, 0, 0, 8'h01, 1, 0);
        applyStimulus("rShift2", 2'b00, 0, 1, 0, 8'h00, 0, 0, 8'h03, 0, 1);

        // New burst accepted in the DONE cycle, then degenerate STARTs
        applyStimulus("dAccept", 2'b10, 0, 0, 0, 8'h00, 1, 1, 8'h03, 1, 0);
        applyStimulus("dShift1", 2'b00, 0, 0, 0, 8'h00, 0, 0, 8'h01, 0, 1);
        applyStimulus("cnt0", 2'b01, 0, 1, 0, 8'h00, 1, 0, 8'h01, 0, 1);
        applyStimulus("cnt0After", 2'b00, 0, 0, 0, 8'h00, 0, 0, 8'h01, 0, 0);
        applyStimulus("startLoad", 2'b11, 0, 0, 0, 8'h3C, 1, 5, 8'h3C, 0, 0);
        applyStimulus("startHold", 2'b00, 0, 0, 0, 8'h00, 1, 5, 8'h3C, 0, 0);

        // Burst longer than WIDTH wraps around
        applyStimulus("wLoad81", 2'b11, 0, 0, 0, 8'h81, 0, 0, 8'h81, 0, 0);
        applyStimulus("wAccept", 2'b01, 1, 0, 0, 8'h00, 1, 9, 8'h81, 1, 0);
        rotExp = 8'h81;
        for (int i = 1; i <= 9; i++) begin
            rotExp = {rotExp[6:0], rotExp[7]};
            applyStimulus($sformatf("wShift%0d", i), 2'b00, 0, 0, 0, 8'h00, 0, 0,
                          rotExp, (i != 9), (i == 9));
        end
        applyStimulus("wAfter", 2'b00, 0, 0, 0, 8'h00, 0, 0, 8'h03, 0, 0);

        $display("[TB] %0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
